cia_ctrl_irq: RTL and testbench

// - Control/interrupt block of the 6526/8521 CIA core: CRA ($E), CRB ($F), ICR ($D), CNT/FLAG edge detectors.
// - Produces per-phi2-cycle timer control strobes, mode bits for ports/serial/TOD, and the open-drain /IRQ level.
// - Sits between the bus decode (rd/we/addr/data) and the timers, serial port and TOD.

---
 rtl/cia_ctrl_irq_if.sv | 25 ++
 rtl/cia_ctrl_irq.sv | 162 ++++++++++++++++
 tb/tb_cia_ctrl_irq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cia_ctrl_irq_if.sv
// Register bus between the CIA address decoder and the control/interrupt block.
// The master drives strobes, address and write data. The slave returns read data.
interface cia_ctrl_irq_if;
   logic       rd;
   logic       we;
   logic [3:0] addr;
   logic [7:0] data;
   logic [7:0] dout;

   modport master (
      output rd,
      output we,
      output addr,
      output data,
      input  dout
   );

   modport slave (
      input  rd,
      input  we,
      input  addr,
      input  data,
      output dout
   );
endinterface

// File: rtl/cia_ctrl_irq.sv
// 6526/8521 CIA control and interrupt block: CRA/CRB/ICR registers, CNT/FLAG edge
// detection, timer count/load strobes and the /IRQ level. All state advances on i_phi2_dn.
module cia_ctrl_irq (
   input  logic             i_clk,
   input  logic             i_res,
   cia_ctrl_irq_if.slave    bus_if,
   input  logic             i_model,
   input  logic             i_phi2_dn,
   input  logic             i_cnt,
   input  logic             i_flag_n,
   input  logic [3:0]       i_sources,
   input  logic             i_ta_ufl,
   input  logic             i_tb_ufl,
   output logic             o_irq_n,
   output logic             o_cnt_up,
   output logic             o_ta_count,
   output logic             o_tb_count,
   output logic             o_ta_load,
   output logic             o_tb_load,
   output logic             o_ta_oneshot,
   output logic             o_ta_outmode,
   output logic             o_ta_pbon,
   output logic             o_tb_oneshot,
   output logic             o_tb_outmode,
   output logic             o_tb_pbon,
   output logic             o_spmode,
   output logic             o_todin,
   output logic             o_alarm
);

   localparam logic [3:0] AddrIcr = 4'hD;
   localparam logic [3:0] AddrCra = 4'hE;
   localparam logic [3:0] AddrCrb = 4'hF;

   logic       r_cnt_prev;
   logic       r_flag_prev;
   logic [7:0] r_cra;
   logic [7:0] r_crb;
   logic [4:0] r_mask;
   logic [4:0] r_flags;
   logic       r_ir;
   logic       r_pend;

   logic       w_cnt_up;
   logic       w_flag_int;
   logic       w_wr_icr;
   logic       w_wr_cra;
   logic       w_wr_crb;
   logic       w_rd_icr;
   logic [7:0] w_cra_d;
   logic [7:0] w_crb_d;
   logic [4:0] w_mask_d;
   logic [4:0] w_flags_d;
   logic       w_pend_d;
   logic       w_ir_d;
   logic       w_tb_src;

   // Edge pulses are suppressed while reset is held, regardless of pin levels.
   assign w_cnt_up   = i_phi2_dn & ~r_cnt_prev & i_cnt & ~i_res;
   assign w_flag_int = i_phi2_dn & r_flag_prev & ~i_flag_n & ~i_res;

   assign w_wr_icr = bus_if.we & (bus_if.addr == AddrIcr);
   assign w_wr_cra = bus_if.we & (bus_if.addr == AddrCra);
   assign w_wr_crb = bus_if.we & (bus_if.addr == AddrCrb);
   assign w_rd_icr = bus_if.rd & (bus_if.addr == AddrIcr);

   always_comb begin
      w_cra_d = r_cra;
      if (w_wr_cra) begin
         w_cra_d = {bus_if.data[7:5], 1'b0, bus_if.data[3:0]};
      end else if (i_ta_ufl & r_cra[3]) begin
         w_cra_d[0] = 1'b0;
      end

      w_crb_d = r_crb;
      if (w_wr_crb) begin
         w_crb_d = {bus_if.data[7:5], 1'b0, bus_if.data[3:0]};
      end else if (i_tb_ufl & r_crb[3]) begin
         w_crb_d[0] = 1'b0;
      end

      w_mask_d = r_mask;
      if (w_wr_icr) begin
         if (bus_if.data[7]) begin
            w_mask_d = r_mask | bus_if.data[4:0];
         end else begin
            w_mask_d = r_mask & ~bus_if.data[4:0];
         end
      end

      // A source pulse coinciding with the ICR read survives the clear.
      w_flags_d = (w_rd_icr ? 5'b00000 : r_flags) | {w_flag_int, i_sources};
      w_pend_d  = |(w_flags_d & w_mask_d);

      // 8521 raises IR on the pending cycle itself; 6526 one PHI2 cycle later.
      w_ir_d = r_ir & ~w_rd_icr;
      if (i_model ? w_pend_d : (r_pend & ~w_rd_icr)) begin
         w_ir_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_cnt_prev  <= 1'b1;
         r_flag_prev <= 1'b1;
         r_cra       <= 8'h00;
         r_crb       <= 8'h00;
         r_mask      <= 5'h00;
         r_flags     <= 5'h00;
         r_ir        <= 1'b0;
         r_pend      <= 1'b0;
      end else if (i_phi2_dn) begin
         r_cnt_prev  <= i_cnt;
         r_flag_prev <= i_flag_n;
         r_cra       <= w_cra_d;
         r_crb       <= w_crb_d;
         r_mask      <= w_mask_d;
         r_flags     <= w_flags_d;
         r_ir        <= w_ir_d;
         r_pend      <= w_pend_d;
      end
   end

   always_comb begin
      w_tb_src = 1'b1;
      unique case (r_crb[6:5])
         2'b00: w_tb_src = 1'b1;
         2'b01: w_tb_src = w_cnt_up;
         2'b10: w_tb_src = i_ta_ufl;
         2'b11: w_tb_src = i_ta_ufl & i_cnt;
      endcase
   end

   assign o_ta_count = r_cra[0] & (r_cra[5] ? w_cnt_up : 1'b1);
   assign o_tb_count = r_crb[0] & w_tb_src;
   assign o_ta_load  = w_wr_cra & bus_if.data[4];
   assign o_tb_load  = w_wr_crb & bus_if.data[4];

   assign o_ta_pbon    = r_cra[1];
   assign o_ta_outmode = r_cra[2];
   assign o_ta_oneshot = r_cra[3];
   assign o_spmode     = r_cra[6];
   assign o_todin      = r_cra[7];
   assign o_tb_pbon    = r_crb[1];
   assign o_tb_outmode = r_crb[2];
   assign o_tb_oneshot = r_crb[3];
   assign o_alarm      = r_crb[7];

   assign o_irq_n  = ~r_ir;
   assign o_cnt_up = w_cnt_up;

   always_comb begin
      bus_if.dout = 8'h00;
      case (bus_if.addr)
         AddrIcr: bus_if.dout = {r_ir, 2'b00, r_flags};
         AddrCra: bus_if.dout = r_cra & 8'hEF;
         AddrCrb: bus_if.dout = r_crb & 8'hEF;
         default: bus_if.dout = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_cia_ctrl_irq.sv
// Bench for cia_ctrl_irq: directed scenarios plus randomized traffic checked against
// a register-level reference model of the CIA control/interrupt behaviour.
module tb_cia_ctrl_irq;

   logic       clk = 1'b0;
   logic       res;
   logic       model;
   logic       phi2_dn;
   logic       cnt;
   logic       flag_n;
   logic [3:0] sources;
   logic       ta_ufl;
   logic       tb_ufl;
   logic       irq_n, cnt_up, ta_count, tb_count, ta_load, tb_load;
   logic       ta_oneshot, ta_outmode, ta_pbon, tb_oneshot, tb_outmode, tb_pbon;
   logic       spmode, todin, alarm;

   cia_ctrl_irq_if u_bus ();

   cia_ctrl_irq u_dut (
      .i_clk        (clk),
      .i_res        (res),
      .bus_if       (u_bus),
      .i_model      (model),
      .i_phi2_dn    (phi2_dn),
      .i_cnt        (cnt),
      .i_flag_n     (flag_n),
      .i_sources    (sources),
      .i_ta_ufl     (ta_ufl),
      .i_tb_ufl     (tb_ufl),
      .o_irq_n      (irq_n),
      .o_cnt_up     (cnt_up),
      .o_ta_count   (ta_count),
      .o_tb_count   (tb_count),
      .o_ta_load    (ta_load),
      .o_tb_load    (tb_load),
      .o_ta_oneshot (ta_oneshot),
      .o_ta_outmode (ta_outmode),
      .o_ta_pbon    (ta_pbon),
      .o_tb_oneshot (tb_oneshot),
      .o_tb_outmode (tb_outmode),
      .o_tb_pbon    (tb_pbon),
      .o_spmode     (spmode),
      .o_todin      (todin),
      .o_alarm      (alarm)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: register contents as the CPU would see them.
   logic [7:0] m_cra, m_crb;
   logic [4:0] m_mask, m_flags;
   logic       m_ir, m_pend, m_cnt_prev, m_flag_prev;

   task automatic model_reset();
      m_cra = 8'h00; m_crb = 8'h00; m_mask = 5'h00; m_flags = 5'h00;
      m_ir = 1'b0; m_pend = 1'b0; m_cnt_prev = 1'b1; m_flag_prev = 1'b1;
   endtask

   function automatic logic [7:0] exp_dout(input logic [3:0] a);
      if (a == 4'hD) return {m_ir, 2'b00, m_flags};
      if (a == 4'hE) return m_cra;
      if (a == 4'hF) return m_crb;
      return 8'h00;
   endfunction

   // Valid only while phi2_dn is high.
   function automatic logic exp_cnt_up();
      return !m_cnt_prev && cnt;
   endfunction

   function automatic logic exp_ta_count();
      if (!m_cra[0]) return 1'b0;
      return m_cra[5] ? exp_cnt_up() : 1'b1;
   endfunction

   function automatic logic exp_tb_count();
      if (!m_crb[0]) return 1'b0;
      case (m_crb[6:5])
         2'd0:    return 1'b1;
         2'd1:    return exp_cnt_up();
         2'd2:    return ta_ufl;
         default: return ta_ufl && cnt;
      endcase
   endfunction

   task automatic model_step();
      logic       icr_rd, pend;
      logic [4:0] nf, nm;
      icr_rd = u_bus.rd && (u_bus.addr == 4'hD);
      nf = (icr_rd ? 5'h00 : m_flags) | {(m_flag_prev && !flag_n), sources};
      nm = m_mask;
      if (u_bus.we && u_bus.addr == 4'hD)
         nm = u_bus.data[7] ? (m_mask | u_bus.data[4:0]) : (m_mask & ~u_bus.data[4:0]);
      if (u_bus.we && u_bus.addr == 4'hE) m_cra = u_bus.data & 8'hEF;
      else if (ta_ufl && m_cra[3]) m_cra = m_cra & 8'hFE;
      if (u_bus.we && u_bus.addr == 4'hF) m_crb = u_bus.data & 8'hEF;
      else if (tb_ufl && m_crb[3]) m_crb = m_crb & 8'hFE;
      pend = |(nf & nm);
      if (model) m_ir = (m_ir && !icr_rd) || pend;
      else       m_ir = (m_ir && !icr_rd) || (m_pend && !icr_rd);
      m_pend = pend;
      m_flags = nf;
      m_mask = nm;
      m_cnt_prev = cnt;
      m_flag_prev = flag_n;
   endtask

   task automatic pulse_begin();
      @(negedge clk);
      phi2_dn = 1'b1;
      #1;
   endtask

   task automatic pulse_end();
      @(negedge clk);
      phi2_dn = 1'b0;
      #1;
   endtask

   task automatic step();
      pulse_begin();
      model_step();
      pulse_end();
   endtask

   task automatic idle_bus();
      u_bus.rd = 1'b0; u_bus.we = 1'b0; u_bus.addr = 4'h0; u_bus.data = 8'h00;
      sources = 4'h0; ta_ufl = 1'b0; tb_ufl = 1'b0;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
      idle_bus();
      u_bus.we = 1'b1; u_bus.addr = a; u_bus.data = d;
      step();
      idle_bus();
   endtask

   task automatic read_icr();
      idle_bus();
      u_bus.rd = 1'b1; u_bus.addr = 4'hD;
      step();
      idle_bus();
   endtask

   task automatic test_reset();
      res = 1'b1; phi2_dn = 1'b0; model = 1'b1; cnt = 1'b1; flag_n = 1'b1;
      idle_bus();
      model_reset();
      #1;
      tests_run++;
      if (irq_n !== 1'b1) begin
         tests_failed++; $display("FAIL reset_irq_n got %b want 1", irq_n);
      end
      // Pins active while reset is held must leave no trace.
      @(negedge clk); phi2_dn = 1'b1; flag_n = 1'b0; sources = 4'hF; cnt = 1'b0;
      @(negedge clk); cnt = 1'b1; #1;
      tests_run++;
      if (cnt_up !== 1'b0) begin
         tests_failed++; $display("FAIL reset_cnt_up got %b want 0", cnt_up);
      end
      @(negedge clk); phi2_dn = 1'b0; flag_n = 1'b1; sources = 4'h0;
      res = 1'b0;
      for (int a = 13; a <= 15; a++) begin
         u_bus.addr = 4'(a); #1;
         tests_run++;
         if (u_bus.dout !== 8'h00) begin
            tests_failed++; $display("FAIL reset_dout_%0d got %h want 00", a, u_bus.dout);
         end
      end
      step();
      tests_run++;
      if (irq_n !== 1'b1 || m_flags !== 5'h00) begin
         tests_failed++; $display("FAIL reset_after_release irq_n=%b want 1", irq_n);
      end
   endtask

   task automatic test_cra_load();
      idle_bus();
      u_bus.we = 1'b1; u_bus.addr = 4'hE; u_bus.data = 8'h11;
      pulse_begin();
      tests_run++;
      if (ta_load !== 1'b1 || tb_load !== 1'b0 || ta_count !== 1'b0) begin
         tests_failed++;
         $display("FAIL cra_write_strobes got load=%b/%b cnt=%b want 1/0/0",
                  ta_load, tb_load, ta_count);
      end
      model_step();
      pulse_end();
      idle_bus();
      for (int i = 0; i < 3; i++) begin
         pulse_begin();
         tests_run++;
         if (ta_count !== 1'b1) begin
            tests_failed++; $display("FAIL cra_count_%0d got %b want 1", i, ta_count);
         end
         model_step();
         pulse_end();
      end
      u_bus.addr = 4'hE; #1;
      tests_run++;
      if (u_bus.dout !== 8'h01) begin
         tests_failed++; $display("FAIL cra_readback got %h want 01", u_bus.dout);
      end
   endtask

   task automatic test_oneshot();
      write_reg(4'hE, 8'h09);
      ta_ufl = 1'b1;
      step();
      idle_bus();
      u_bus.addr = 4'hE; #1;
      tests_run++;
      if (u_bus.dout !== 8'h08 || ta_count !== 1'b0 || ta_oneshot !== 1'b1) begin
         tests_failed++;
         $display("FAIL oneshot_stop got cra=%h count=%b want 08/0", u_bus.dout, ta_count);
      end
      // Coincident CPU write wins over the one-shot stop.
      write_reg(4'hE, 8'h09);
      u_bus.we = 1'b1; u_bus.addr = 4'hE; u_bus.data = 8'h0B; ta_ufl = 1'b1;
      step();
      idle_bus();
      u_bus.addr = 4'hE; #1;
      tests_run++;
      if (u_bus.dout !== 8'h0B || ta_pbon !== 1'b1) begin
         tests_failed++; $display("FAIL oneshot_write_wins got %h want 0b", u_bus.dout);
      end
   endtask

   task automatic test_crb_modes();
      logic u;
      write_reg(4'hF, 8'h41);
      for (int i = 0; i < 6; i++) begin
         u = 1'($urandom_range(0, 1));
         ta_ufl = u;
         pulse_begin();
         tests_run++;
         if (tb_count !== u) begin
            tests_failed++; $display("FAIL crb_ta_ufl_%0d got %b want %b", i, tb_count, u);
         end
         model_step();
         pulse_end();
      end
      write_reg(4'hF, 8'h61);
      for (int i = 0; i < 8; i++) begin
         cnt = (i >= 4);
         u = (i == 4 || i == 6) ? 1'b1 : 1'($urandom_range(0, 1));
         ta_ufl = u;
         pulse_begin();
         tests_run++;
         if (tb_count !== (u & cnt)) begin
            tests_failed++;
            $display("FAIL crb_ta_ufl_cnt_%0d got %b want %b", i, tb_count, u & cnt);
         end
         model_step();
         pulse_end();
      end
      idle_bus();
   endtask

   task automatic test_icr_model1();
      model = 1'b1;
      read_icr();
      write_reg(4'hD, 8'h81);
      sources = 4'h1;
      step();
      sources = 4'h0;
      u_bus.addr = 4'hD; #1;
      tests_run++;
      if (irq_n !== 1'b0 || u_bus.dout !== 8'h81) begin
         tests_failed++;
         $display("FAIL icr8521_assert got irq_n=%b icr=%h want 0/81", irq_n, u_bus.dout);
      end
      read_icr();
      tests_run++;
      if (irq_n !== 1'b1) begin
         tests_failed++; $display("FAIL icr8521_clear got irq_n=%b want 1", irq_n);
      end
   endtask

   task automatic test_icr_model0();
      model = 1'b0;
      sources = 4'h1;
      step();
      sources = 4'h0;
      tests_run++;
      if (irq_n !== 1'b1) begin
         tests_failed++; $display("FAIL icr6526_early got irq_n=%b want 1", irq_n);
      end
      step();
      u_bus.addr = 4'hD; #1;
      tests_run++;
      if (irq_n !== 1'b0 || u_bus.dout !== 8'h81) begin
         tests_failed++;
         $display("FAIL icr6526_late got irq_n=%b icr=%h want 0/81", irq_n, u_bus.dout);
      end
      read_icr();
      step();
      tests_run++;
      if (irq_n !== 1'b1) begin
         tests_failed++; $display("FAIL icr6526_clear got irq_n=%b want 1", irq_n);
      end
      model = 1'b1;
   endtask

   task automatic test_flag();
      write_reg(4'hD, 8'h10);
      flag_n = 1'b0;
      step();
      flag_n = 1'b1;
      u_bus.addr = 4'hD; #1;
      tests_run++;
      if (irq_n !== 1'b1 || u_bus.dout !== 8'h10) begin
         tests_failed++;
         $display("FAIL flag_masked got irq_n=%b icr=%h want 1/10", irq_n, u_bus.dout);
      end
      write_reg(4'hD, 8'h90);
      tests_run++;
      if (irq_n !== 1'b0) begin
         tests_failed++; $display("FAIL flag_unmask got irq_n=%b want 0", irq_n);
      end
      read_icr();
   endtask

   task automatic test_collision();
      // Mask is {flag, ta}; tb flag is recorded but does not interrupt.
      u_bus.rd = 1'b1; u_bus.addr = 4'hD; sources = 4'h2;
      step();
      idle_bus();
      u_bus.addr = 4'hD; #1;
      tests_run++;
      if (u_bus.dout !== 8'h02 || irq_n !== 1'b1) begin
         tests_failed++; $display("FAIL collide_tb got icr=%h want 02", u_bus.dout);
      end
      u_bus.rd = 1'b1; u_bus.addr = 4'hD; sources = 4'h1;
      step();
      idle_bus();
      u_bus.addr = 4'hD; #1;
      tests_run++;
      if (u_bus.dout !== 8'h81 || irq_n !== 1'b0) begin
         tests_failed++;
         $display("FAIL collide_ta got icr=%h irq_n=%b want 81/0", u_bus.dout, irq_n);
      end
      read_icr();
   endtask

   task automatic test_async_reset();
      write_reg(4'hE, 8'h01);
      sources = 4'h1;
      step();
      idle_bus();
      u_bus.addr = 4'hE;
      @(posedge clk); #2;
      res = 1'b1; #1;
      tests_run++;
      if (irq_n !== 1'b1 || u_bus.dout !== 8'h00 || ta_count !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset got irq_n=%b cra=%h want 1/00", irq_n, u_bus.dout);
      end
      @(negedge clk); res = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic [7:0] exp_d;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 31) == 0) model = ~model;
         cnt     = 1'($urandom_range(0, 1));
         flag_n  = ($urandom_range(0, 3) != 0);
         sources = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         ta_ufl  = ($urandom_range(0, 3) == 0);
         tb_ufl  = ($urandom_range(0, 3) == 0);
         u_bus.addr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(13, 15));
         u_bus.data = 8'($urandom);
         u_bus.we   = ($urandom_range(0, 3) == 0);
         u_bus.rd   = !u_bus.we && ($urandom_range(0, 3) == 0);
         pulse_begin();
         exp_d = exp_dout(u_bus.addr);
         tests_run++;
         if (u_bus.dout !== exp_d || irq_n !== !m_ir) begin
            tests_failed++;
            $display("FAIL rnd_read_%0d addr=%h got %h/%b want %h/%b", i, u_bus.addr,
                     u_bus.dout, irq_n, exp_d, !m_ir);
         end
         tests_run++;
         if (cnt_up !== exp_cnt_up() || ta_count !== exp_ta_count()
             || tb_count !== exp_tb_count()) begin
            tests_failed++;
            $display("FAIL rnd_count_%0d got up=%b ta=%b tb=%b want %b/%b/%b", i, cnt_up,
                     ta_count, tb_count, exp_cnt_up(), exp_ta_count(), exp_tb_count());
         end
         tests_run++;
         if (ta_load !== (u_bus.we && u_bus.addr == 4'hE && u_bus.data[4])
             || tb_load !== (u_bus.we && u_bus.addr == 4'hF && u_bus.data[4])) begin
            tests_failed++; $display("FAIL rnd_load_%0d got %b/%b", i, ta_load, tb_load);
         end
         model_step();
         pulse_end();
         tests_run++;
         if (cnt_up !== 1'b0 || irq_n !== !m_ir || alarm !== m_crb[7] || todin !== m_cra[7]
             || spmode !== m_cra[6] || tb_oneshot !== m_crb[3] || tb_outmode !== m_crb[2]
             || ta_outmode !== m_cra[2] || tb_pbon !== m_crb[1]) begin
            tests_failed++;
            $display("FAIL rnd_post_%0d got irq_n=%b up=%b want %b/0", i, irq_n, cnt_up, !m_ir);
         end
      end
      idle_bus();
   endtask

   initial begin
      test_reset();
      test_cra_load();
      test_oneshot();
      test_crb_modes();
      test_icr_model1();
      test_icr_model0();
      test_flag();
      test_collision();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
